// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the N-channel stream multiplexer.
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int unsigned ptr_inc(input int unsigned p, input int unsigned n);
    return (p + 1 >= n) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Wrap-around priority search: first requesting channel at or after ptr.
module rr_pick #(
  parameter int N_CH  = 4,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_any
);

  int idx;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 0; k < N_CH; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!gnt_any && req[idx[SEL_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = idx[SEL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/stream_mux_n.sv
// N-channel W-bit stream multiplexer: fixed or round-robin selection into a
// single registered valid/ready output with 1-cycle latency.
module stream_mux_n
  import stream_mux_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = $clog2(N_CH),
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       sel,
  input  logic [N_CH-1:0]        in_valid,
  input  logic [N_CH*DATA_W-1:0] in_data,
  output logic [N_CH-1:0]        in_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic [SEL_W-1:0]       out_ch,
  input  logic                   out_ready,
  output logic [CNT_W-1:0]       beat_cnt
);

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0]  out_ch_q,    out_ch_d;
  logic [CNT_W-1:0]  beat_cnt_q,  beat_cnt_d;
  logic [SEL_W-1:0]  ptr_q,       ptr_d;

  logic              load;
  logic              sel_ok;
  logic              fix_any;
  logic              rr_any;
  logic [SEL_W-1:0]  rr_idx;
  logic              gnt_any;
  logic [SEL_W-1:0]  gnt_idx;
  logic              hs;

  rr_pick #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_rr_pick (
    .req     (in_valid),
    .ptr     (ptr_q),
    .gnt_idx (rr_idx),
    .gnt_any (rr_any)
  );

  // Out-of-range sel on non-power-of-2 channel counts must never grant.
  always_comb begin
    load    = !out_valid_q || out_ready;
    sel_ok  = int'(sel) < N_CH;
    fix_any = sel_ok && in_valid[sel];
    if (mode == MODE_RR) begin
      gnt_any = rr_any;
      gnt_idx = rr_idx;
    end else begin
      gnt_any = fix_any;
      gnt_idx = sel;
    end
    hs       = !rst && load && gnt_any;
    in_ready = hs ? (N_CH'(1) << gnt_idx) : '0;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    beat_cnt_d  = beat_cnt_q;
    ptr_d       = ptr_q;
    if (hs) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[int'(gnt_idx)*DATA_W +: DATA_W];
      out_ch_d    = gnt_idx;
      beat_cnt_d  = beat_cnt_q + CNT_W'(1);
      if (mode == MODE_RR)
        ptr_d = SEL_W'(ptr_inc(32'(gnt_idx), 32'(N_CH)));
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      beat_cnt_q  <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      beat_cnt_q  <= beat_cnt_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_stream_mux_n.sv
// Directed plus randomized bench for stream_mux_n against a behavioural model.
module tb_stream_mux_n;

  localparam int N      = 4;
  localparam int DW     = 8;
  localparam int SW     = 2;
  localparam int CW     = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            mode;
  logic [SW-1:0]   sel;
  logic [N-1:0]    in_valid;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [SW-1:0]   out_ch;
  logic            out_ready;
  logic [CW-1:0]   beat_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state
  logic          m_valid;
  logic [DW-1:0] m_data;
  int            m_ch;
  int            m_cnt;
  int            m_ptr;
  int            m_gnt;

  stream_mux_n #(.N_CH(N), .DATA_W(DW), .SEL_W(SW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready),
    .beat_cnt  (beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Which channel the rules say is granted this cycle, or -1.
  function automatic int model_grant();
    logic [N-1:0] v;
    int s;
    v = in_valid;
    s = int'(sel);
    if (rst) return -1;
    if (m_valid && !out_ready) return -1;
    if (mode == 1'b0) begin
      if (s < N && v[s] === 1'b1) return s;
      return -1;
    end
    for (int k = 0; k < N; k++)
      if (v[(m_ptr + k) % N] === 1'b1) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic cycle();
    logic [N-1:0] exp_rdy;
    logic [N*DW-1:0] d;
    @(negedge clk);
    m_gnt   = model_grant();
    exp_rdy = '0;
    if (m_gnt >= 0) exp_rdy[m_gnt] = 1'b1;
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    if (m_valid) begin
      chk("out_data", 64'(out_data), 64'(m_data));
      chk("out_ch", 64'(out_ch), 64'(m_ch));
    end
    chk("beat_cnt", 64'(beat_cnt), 64'(m_cnt));
    d = in_data;
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0; m_data = '0; m_ch = 0; m_cnt = 0; m_ptr = 0;
    end else if (m_gnt >= 0) begin
      m_valid = 1'b1;
      m_data  = d[m_gnt*DW +: DW];
      m_ch    = m_gnt;
      m_cnt   = (m_cnt + 1) % 65536;
      if (mode) m_ptr = (m_gnt + 1) % N;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  initial begin
    logic [7:0] bp_first;
    m_valid = 0; m_data = '0; m_ch = 0; m_cnt = 0; m_ptr = 0; m_gnt = -1;
    rst = 1; mode = 0; sel = '0; in_valid = '0; in_data = '0; out_ready = 1;
    @(posedge clk); #1;
    cycle();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_cnt", 64'(beat_cnt), 64'd0);
    rst = 0;

    // Fixed sweep
    in_data = 32'hD4C3B2A1; in_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      sel = SW'(i);
      cycle();
      chk("sweep_ch", 64'(out_ch), 64'(i));
      chk("sweep_data", 64'(out_data), 64'(8'hA1 + 8'h11 * i));
    end
    chk("sweep_cnt", 64'(beat_cnt), 64'd4);

    // Fixed select on an idle channel
    sel = 2'd2; in_valid = 4'b1011;
    cycle();
    chk("idle_valid", 64'(out_valid), 64'd0);
    chk("idle_cnt", 64'(beat_cnt), 64'd4);

    // RR fairness
    mode = 1; in_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("rr_ch", 64'(out_ch), 64'(i % 4));
    end

    // RR skip and wrap
    in_valid = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("rr_skip_ch", 64'((i % 2) ? 3 : 0), 64'(out_ch));
    end

    // Backpressure
    mode = 0; sel = 2'd0; in_valid = 4'b0001; in_data = 32'h000000A1;
    cycle();
    bp_first = out_data;
    chk("bp_first", 64'(bp_first), 64'hA1);
    out_ready = 0; in_data = 32'h00000055;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_hold_data", 64'(out_data), 64'hA1);
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1;
    cycle();
    chk("bp_next_data", 64'(out_data), 64'h55);
    chk("bp_next_valid", 64'(out_valid), 64'd1);

    // Reset mid-stream, X on idle lanes
    mode = 1; in_valid = 4'b1111; in_data = 32'h44332211;
    cycle();
    cycle();
    rst = 1;
    cycle();
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_cnt", 64'(beat_cnt), 64'd0);
    rst = 0; in_valid = 4'b0101; in_data = {8'hxx, 8'h33, 8'hxx, 8'h11};
    cycle();
    chk("post_rst_ch", 64'(out_ch), 64'd0);
    chk("post_rst_data", 64'(out_data), 64'h11);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      mode      = 1'($urandom);
      sel       = SW'($urandom);
      in_valid  = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 49) == 0);
      in_data   = $urandom;
      if ($urandom_range(0, 1) == 1)
        for (int c = 0; c < N; c++)
          if (!in_valid[c]) in_data[c*DW +: DW] = 'x;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_mux_n.md
Name: stream_mux_n

Overview:
- Parametrised N-channel, W-bit successor to the team's 4:1 bit mux.
- Selects one input channel per cycle and registers the chosen word onto a valid/ready output stream.
- Two selection modes: fixed (external `sel`) and round-robin arbitration.
- Sits between multiple producer lanes and a single consumer in the lab datapath, with 1-cycle latency and full throughput.

Parameters:
- N_CH, 4, number of input channels (2..16).
- DATA_W, 8, width of each channel's data word.
- SEL_W, $clog2(N_CH), width of `sel` and `out_ch`.
- CNT_W, 16, width of the accepted-beat counter.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  reset, synchronous, active-high.
- mode  in  1  0 = fixed select via `sel`, 1 = round-robin.
- sel  in  SEL_W  channel index used in fixed mode.
- in_valid  in  N_CH  per-channel valid.
- in_data  in  N_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- in_ready  out  N_CH  per-channel ready; one-hot or zero.
- out_valid  out  1  output word valid.
- out_data  out  DATA_W  registered selected word.
- out_ch  out  SEL_W  index of the channel that produced `out_data`.
- out_ready  in  1  consumer ready.
- beat_cnt  out  CNT_W  count of beats accepted from inputs, wraps.

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, out_data=0, out_ch=0, beat_cnt=0, rr pointer=0.
- in_ready is combinationally 0 while rst=1.
- load = !out_valid || out_ready. The output register may take a new beat only when load=1.
- Fixed mode:
  - Candidate is `sel`.
  - Grant when load && in_valid[sel] && sel<N_CH.
  - sel>=N_CH (non-power-of-2 N_CH) yields no grant.
- Round-robin mode:
  - Search channels ptr, ptr+1, ..., wrapping modulo N_CH; the first with in_valid=1 is the candidate.
  - Grant when load && a candidate exists.
  - On grant, ptr <= (grant+1) mod N_CH. Wrap from N_CH-1 goes to 0.
  - No grant: ptr holds.
- Pointer is updated only in RR mode. It is retained across mode switches.
- A mode or sel change affects arbitration in the same cycle; there is no state flush.
- in_ready[g]=1 only for the granted channel g. A handshake occurs when in_valid[g] && in_ready[g].
- On handshake, at the next edge:
  - out_data <= in_data[g]
  - out_ch <= g
  - out_valid <= 1
  - beat_cnt <= beat_cnt+1 (wraps at 2^CNT_W to 0)
- No handshake and out_ready=1 with out_valid=1: out_valid <= 0 next edge.
- Backpressure: while out_valid && !out_ready, out_data and out_ch hold stable and all in_ready=0.
- Simultaneous consume and load (out_valid=1, out_ready=1, new grant): the new word replaces the old with no bubble. Sustained throughput is 1 beat/clk.
- Latency: input handshake at edge k gives out_valid=1 with the data after edge k.
- Reset mid-transfer: the pending output word is discarded and the pointer returns to 0. No handshake is reported in the reset cycle.
- in_data of non-granted channels is ignored. X on those lanes must not propagate.

Decomposition:
- Package stream_mux_pkg:
  - MODE_FIXED=1'b0 and MODE_RR=1'b1 constants.
  - A function for modulo-N increment of the pointer.
- One sub-module, rr_pick:
  - Combinational.
  - Inputs: req[N_CH], ptr[SEL_W].
  - Outputs: gnt_idx[SEL_W], gnt_any.
  - Implements the wrap-around priority search.
- The top holds the output register, the pointer, the counter and the mode mux.

Test Plan:
- Fixed sweep:
  - Stimulus: mode=0, in_data={8'hD4,8'hC3,8'hB2,8'hA1}, all valid, out_ready=1; sel=0,1,2,3 each for one clk.
  - Response: out_data A1,B2,C3,D4 one cycle later; out_ch 0..3; beat_cnt=4.
- Fixed, sel on idle channel:
  - Stimulus: mode=0, sel=2, in_valid=4'b1011.
  - Response: in_ready=0, out_valid falls to 0, beat_cnt unchanged.
- RR fairness:
  - Stimulus: mode=1, in_valid=4'b1111 held, out_ready=1 for 8 clks.
  - Response: out_ch 0,1,2,3,0,1,2,3; each in_ready pulse one-hot.
- RR skip and wrap:
  - Stimulus: mode=1, in_valid=4'b1001.
  - Response: grants alternate 0,3,0,3; pointer wraps 3→0.
- Backpressure:
  - Stimulus: out_ready=0 for 3 clks after first beat 8'hA1.
  - Response: out_data stays A1, out_valid=1, in_ready=0; out_ready=1 then accepts the next beat with no bubble.
- Reset mid-stream:
  - Stimulus: assert rst for 1 clk during RR with out_valid=1.
  - Response: next cycle out_valid=0, beat_cnt=0; first grant after reset goes to channel 0.
